// File: rtl/bcd_seven_seg_scanner.sv
// Time-multiplexed driver for a three-digit common-anode seven-segment display.
// Holds a BCD value, scans ones/tens/hundreds at REFRESH_DIV cycles per digit, with optional leading-zero blanking.
module bcd_seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd,
    input  logic        bcd_valid,
    input  logic        blank_lz,
    input  logic        en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [11:0]   held_q, held_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          tick;
    logic [3:0]    digit;
    logic          blank_digit;

    // Segment patterns {g,f,e,d,c,b,a}, active-low; non-decimal nibbles show a dash.
    function automatic logic [6:0] encode(input logic [3:0] nib);
        case (nib)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        held_d = bcd_valid ? bcd : held_q;
        tick   = (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end
        end

        case (idx_q)
            2'd0:    digit = held_q[3:0];
            2'd1:    digit = held_q[7:4];
            default: digit = held_q[11:8];
        endcase

        // Only a literal zero counts as leading; a dash nibble stops blanking.
        blank_digit = blank_lz &&
                      (((idx_q == 2'd2) && (held_q[11:8] == 4'd0)) ||
                       ((idx_q == 2'd1) && (held_q[11:8] == 4'd0) && (held_q[7:4] == 4'd0)));

        if (!en || blank_digit) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = encode(digit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_q <= '0;
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
        end else begin
            held_q <= held_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule
